// File: rtl/xtea_mode_ctrl.sv
// ECB/CBC block sequencer in front of an iterative XTEA core.
// Accepts blocks on a valid/ready interface and applies CBC chaining with IV handling.
// It drives the core's start pulse and direction flag and watches for a missing result
// strobe with a timeout counter.
module xtea_mode_ctrl #(
    parameter int unsigned TO_W = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mode,
    input  logic        i_flag,
    input  logic [63:0] i_iv,
    input  logic        i_iv_load,
    input  logic [63:0] i_din,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    output logic [63:0] o_dout,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic        o_busy,
    output logic        o_err,
    output logic [63:0] o_core_din,
    output logic        o_core_din_en,
    output logic        o_core_flag,
    input  logic [63:0] i_core_dout,
    input  logic        i_core_dout_en
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

    localparam logic [TO_W-1:0] ToMax = {TO_W{1'b1}};

    state_e          state_q, state_d;
    logic [63:0]     chain_q, chain_d;
    logic [63:0]     blk_q, blk_d;
    logic [63:0]     in_q, in_d;
    logic [63:0]     dout_q, dout_d;
    logic            mode_q, mode_d;
    logic            flag_q, flag_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0] cnt_inc;
    logic [63:0]     chain_eff;

    assign cnt_inc   = cnt_q + 1'b1;
    // An IV loaded in the accept cycle already applies to that block.
    assign chain_eff = i_iv_load ? i_iv : chain_q;

    // Next-state logic: block accept, core start, result capture, timeout.
    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        blk_d   = blk_q;
        in_d    = in_q;
        dout_d  = dout_q;
        mode_d  = mode_q;
        flag_d  = flag_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (i_iv_load) begin
                    chain_d = i_iv;
                end
                if (i_din_valid) begin
                    mode_d  = i_mode;
                    flag_d  = i_flag;
                    in_d    = i_din;
                    blk_d   = (i_mode && i_flag) ? (i_din ^ chain_eff) : i_din;
                    state_d = StStart;
                end
            end
            StStart: begin
                // Counter starts from zero here and counts the start cycle itself, so the
                // timeout fires in the cycle 2^TO_W-1 cycles after the start pulse.
                cnt_d   = cnt_inc;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (i_core_dout_en) begin
                    // A strobe coinciding with the timeout still wins.
                    state_d = StOut;
                    if (mode_q && !flag_q) begin
                        dout_d  = i_core_dout ^ chain_q;
                        chain_d = in_q;
                    end else begin
                        dout_d = i_core_dout;
                        if (mode_q) begin
                            chain_d = i_core_dout;
                        end
                    end
                end else if (cnt_inc == ToMax) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StOut: begin
                if (i_dout_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            chain_q <= '0;
            blk_q   <= '0;
            in_q    <= '0;
            dout_q  <= '0;
            mode_q  <= 1'b0;
            flag_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            blk_q   <= blk_d;
            in_q    <= in_d;
            dout_q  <= dout_d;
            mode_q  <= mode_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode purely from registered state.
    always_comb begin
        o_din_ready   = (state_q == StIdle);
        o_busy        = (state_q != StIdle);
        o_dout_valid  = (state_q == StOut);
        o_core_din_en = (state_q == StStart);
        o_core_din    = blk_q;
        o_core_flag   = flag_q;
        o_dout        = dout_q;
        o_err         = err_q;
    end

endmodule

// File: tb/tb_xtea_mode_ctrl.sv
// Directed bench for xtea_mode_ctrl with a fixed-latency XOR core stub.
module tb_xtea_mode_ctrl;

    localparam logic [63:0] Mask = 64'hFFFF0000FFFF0000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_mode;
    logic        i_flag;
    logic [63:0] i_iv;
    logic        i_iv_load;
    logic [63:0] i_din;
    logic        i_din_valid;
    logic        o_din_ready;
    logic [63:0] o_dout;
    logic        o_dout_valid;
    logic        i_dout_ready;
    logic        o_busy;
    logic        o_err;
    logic [63:0] o_core_din;
    logic        o_core_din_en;
    logic        o_core_flag;
    logic [63:0] i_core_dout    = '0;
    logic        i_core_dout_en = 1'b0;

    logic [3:0]  stub_cnt  = '0;
    logic [63:0] stub_din  = '0;
    logic        stub_drop = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    xtea_mode_ctrl #(.TO_W(4)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_mode         (i_mode),
        .i_flag         (i_flag),
        .i_iv           (i_iv),
        .i_iv_load      (i_iv_load),
        .i_din          (i_din),
        .i_din_valid    (i_din_valid),
        .o_din_ready    (o_din_ready),
        .o_dout         (o_dout),
        .o_dout_valid   (o_dout_valid),
        .i_dout_ready   (i_dout_ready),
        .o_busy         (o_busy),
        .o_err          (o_err),
        .o_core_din     (o_core_din),
        .o_core_din_en  (o_core_din_en),
        .o_core_flag    (o_core_flag),
        .i_core_dout    (i_core_dout),
        .i_core_dout_en (i_core_dout_en)
    );

    always #5 clk = ~clk;

    // Core stub: result = din ^ Mask, strobe 7 cycles after the start pulse.
    always @(posedge clk) begin
        i_core_dout_en <= 1'b0;
        if (o_core_din_en) begin
            stub_cnt <= 4'd6;
            stub_din <= o_core_din;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 4'd1;
            if (stub_cnt == 4'd1 && !stub_drop) begin
                i_core_dout_en <= 1'b1;
                i_core_dout    <= stub_din ^ Mask;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_iv(input logic [63:0] iv);
        @(negedge clk);
        i_iv      = iv;
        i_iv_load = 1'b1;
        @(negedge clk);
        i_iv_load = 1'b0;
    endtask

    // Presents one block, then checks the start cycle; returns at the START negedge.
    task automatic accept(input logic mode, input logic flag, input logic [63:0] din,
                          input logic ivl, input logic [63:0] iv,
                          input logic [63:0] exp_core, input string tag);
        @(negedge clk);
        check({tag, "_din_ready"}, 64'(o_din_ready), 64'd1);
        i_mode      = mode;
        i_flag      = flag;
        i_din       = din;
        i_iv_load   = ivl;
        i_iv        = iv;
        i_din_valid = 1'b1;
        @(negedge clk);
        i_din_valid = 1'b0;
        i_iv_load   = 1'b0;
        i_din       = ~din;
        i_mode      = ~mode;
        i_flag      = ~flag;
        check({tag, "_start_en"}, 64'(o_core_din_en), 64'd1);
        check({tag, "_core_din"}, o_core_din, exp_core);
        check({tag, "_core_flag"}, 64'(o_core_flag), 64'(flag));
    endtask

    task automatic run_block(input logic mode, input logic flag, input logic [63:0] din,
                             input logic ivl, input logic [63:0] iv,
                             input logic [63:0] exp_core, input logic [63:0] exp_dout,
                             input int hold, input string tag);
        int lat;
        i_dout_ready = (hold == 0);
        accept(mode, flag, din, ivl, iv, exp_core, tag);
        lat = 1;
        while (o_dout_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd9);
        check({tag, "_dout"}, o_dout, exp_dout);
        check({tag, "_flag_out"}, 64'(o_core_flag), 64'(flag));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(o_dout_valid), 64'd1);
            check({tag, "_hold_dout"}, o_dout, exp_dout);
            check({tag, "_hold_ready"}, 64'(o_din_ready), 64'd0);
            check({tag, "_hold_busy"}, 64'(o_busy), 64'd1);
        end
        i_dout_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(o_dout_valid), 64'd0);
        check({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        int  k;
        logic seen_valid;
        i_rst        = 1'b1;
        i_mode       = 1'b0;
        i_flag       = 1'b0;
        i_iv         = '0;
        i_iv_load    = 1'b0;
        i_din        = '0;
        i_din_valid  = 1'b0;
        i_dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        check("rst_dout", o_dout, 64'd0);
        check("rst_core_din", o_core_din, 64'd0);
        check("rst_core_flag", 64'(o_core_flag), 64'd1);
        check("rst_valid", 64'(o_dout_valid), 64'd0);
        check("rst_start_en", 64'(o_core_din_en), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_ready", 64'(o_din_ready), 64'd1);

        // ECB encrypt
        run_block(1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0, 64'd0,
                  64'h0123456789ABCDEF, 64'hFEDC45677654CDEF, 0, "ecb");

        // CBC encrypt chain
        load_iv(64'h1111111111111111);
        run_block(1'b1, 1'b1, 64'd0, 1'b0, 64'd0,
                  64'h1111111111111111, 64'hEEEE1111EEEE1111, 0, "cbce0");
        run_block(1'b1, 1'b1, 64'd0, 1'b0, 64'd0,
                  64'hEEEE1111EEEE1111, 64'h1111111111111111, 0, "cbce1");

        // CBC decrypt chain, second block under backpressure
        load_iv(64'h1111111111111111);
        run_block(1'b1, 1'b0, 64'hEEEE1111EEEE1111, 1'b0, 64'd0,
                  64'hEEEE1111EEEE1111, 64'd0, 0, "cbcd0");
        run_block(1'b1, 1'b0, 64'd0, 1'b0, 64'd0,
                  64'd0, 64'h1111111111111111, 5, "cbcd1");

        // IV load in the accept cycle uses the new IV
        run_block(1'b1, 1'b1, 64'd0, 1'b1, 64'h2222222222222222,
                  64'h2222222222222222, 64'hDDDD2222DDDD2222, 0, "ivacc");

        // Timeout: no strobe from the stub
        stub_drop = 1'b1;
        accept(1'b1, 1'b1, 64'd0, 1'b0, 64'd0, 64'hDDDD2222DDDD2222, "to");
        k = 0;
        seen_valid = 1'b0;
        while (o_err !== 1'b1 && k < 30) begin
            @(negedge clk);
            seen_valid = seen_valid | o_dout_valid;
            k++;
        end
        check("to_latency", 64'(k), 64'd15);
        check("to_no_valid", 64'(seen_valid), 64'd0);
        check("to_idle", 64'(o_busy), 64'd0);
        @(negedge clk);
        check("to_err_pulse", 64'(o_err), 64'd0);
        stub_drop = 1'b0;
        run_block(1'b1, 1'b1, 64'd0, 1'b0, 64'd0,
                  64'hDDDD2222DDDD2222, 64'h2222222222222222, 0, "after_to");

        // Reset during WAIT; the stub's late strobe must be ignored
        accept(1'b1, 1'b1, 64'd0, 1'b0, 64'd0, 64'h2222222222222222, "rs");
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("rs_busy", 64'(o_busy), 64'd0);
        check("rs_ready", 64'(o_din_ready), 64'd1);
        check("rs_core_din", o_core_din, 64'd0);
        check("rs_core_flag", 64'(o_core_flag), 64'd1);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_valid = seen_valid | o_dout_valid | o_busy;
        end
        check("rs_late_strobe", 64'(seen_valid), 64'd0);
        run_block(1'b1, 1'b1, 64'h5555555555555555, 1'b0, 64'd0,
                  64'h5555555555555555, 64'hAAAA5555AAAA5555, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
